// File: rtl/mem_access_unit.sv
// RV32I memory stage: drives a request/ack data-memory port,
// lane-shifts stores and aligns/extends loads for writeback.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  done,
  output logic                  resp_we,
  output logic [4:0]            resp_rd,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  fault,
  output logic                  stall
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]            state;
  logic                  st_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [4:0]            rd_q;
  logic                  illegal;
  logic [1:0]            off;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] lanes;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] ld;

  always_comb begin
    illegal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = req_addr[0];
      3'b010:         illegal = |req_addr[1:0];
      default:        illegal = 1'b1;
    endcase
    if (req_is_store && req_funct3[2])
      illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            st_q    <= req_is_store;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            state   <= illegal ? FAULT : BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign off = addr_q[1:0];

  always_comb begin
    be    = 4'b1111;
    lanes = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << off;
        lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        lanes = wdata_q;
      end
    endcase
  end

  assign shifted = rdata_q >> {off, 3'b000};

  always_comb begin
    ld = rdata_q;
    unique case (f3_q)
      3'b000:  ld = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld = {24'd0, shifted[7:0]};
      3'b101:  ld = {16'd0, shifted[15:0]};
      default: ld = rdata_q;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign stall     = ~req_ready;
  assign mem_req   = (state == BUSY);
  assign mem_we    = mem_req & st_q;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = lanes;
  assign mem_be    = mem_we ? be : 4'b0000;
  assign done      = (state == RESP);
  assign fault     = (state == FAULT);
  assign resp_we   = done & ~st_q;
  assign resp_rd   = resp_we ? rd_q : 5'd0;
  assign resp_data = resp_we ? ld : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed loads, stores,
// faults, mid-transaction reset and back-to-back acceptance.
module tb_mem_access_unit;

  typedef struct packed {
    logic        is_fault;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memx_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        req_valid = 0;
  logic        req_ready;
  logic        req_is_store = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0;
  logic [31:0] req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 0;
  logic [31:0] mem_rdata = 0;
  logic        done, resp_we, fault, stall;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [31:0] ack_rdata = 0;
  bit manual = 0;

  resp_t exp_resp[$];
  memx_t exp_mem[$];

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .done(done), .resp_we(resp_we), .resp_rd(resp_rd),
    .resp_data(resp_data), .fault(fault), .stall(stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: acks ack_delay cycles after mem_req rises
  initial forever begin
    @(posedge clk);
    #1;
    if (!manual) begin
      if (mem_ack) begin
        mem_ack = 0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1;
          mem_rdata = ack_rdata;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // monitor
  initial forever begin
    resp_t r;
    memx_t m;
    @(negedge clk);
    chk("stall_vs_ready", {31'd0, stall}, {31'd0, ~req_ready});
    if (mem_req && mem_ack) begin
      if (exp_mem.size() == 0) begin
        chk("unexpected_mem", 32'd1, 32'd0);
      end else begin
        m = exp_mem.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
        chk("mem_addr", mem_addr, m.addr);
        chk("mem_be", {28'd0, mem_be}, {28'd0, m.be});
        if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
      end
    end
    if (done || fault) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_resp", {30'd0, done, fault}, 32'd0);
      end else begin
        r = exp_resp.pop_front();
        chk("fault", {31'd0, fault}, {31'd0, r.is_fault});
        chk("done", {31'd0, done}, {31'd0, ~r.is_fault});
        chk("resp_we", {31'd0, resp_we}, {31'd0, r.we});
        chk("resp_rd", {27'd0, resp_rd}, {27'd0, r.rd});
        chk("resp_data", resp_data, r.data);
      end
    end
  end

  task automatic wait_accept(output int cyc);
    int b = 0;
    @(negedge clk);
    while (!req_ready && b < 50) begin
      @(negedge clk);
      b++;
    end
    if (b >= 50) chk("accept_timeout", 32'd1, 32'd0);
    cyc = cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(bit st, logic [2:0] f3,
                         logic [31:0] a, logic [31:0] wd,
                         logic [4:0] rd);
    req_is_store = st;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_rd = rd;
    req_valid = 1;
  endtask

  task automatic issue(bit st, logic [2:0] f3,
                       logic [31:0] a, logic [31:0] wd,
                       logic [4:0] rd);
    int c;
    set_req(st, f3, a, wd, rd);
    wait_accept(c);
    req_valid = 0;
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_resp.size() != 0 || exp_mem.size() != 0)
           && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (b >= 100) chk("drain_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic ld(logic [2:0] f3, logic [31:0] a,
                    logic [31:0] rdat, logic [4:0] rd,
                    logic [31:0] exp, int dly);
    ack_delay = dly;
    ack_rdata = rdat;
    exp_mem.push_back('{1'b0, {a[31:2], 2'b00}, 4'b0000, 32'd0});
    exp_resp.push_back('{1'b0, 1'b1, rd, exp});
    issue(0, f3, a, 32'd0, rd);
    drain();
  endtask

  task automatic st(logic [2:0] f3, logic [31:0] a,
                    logic [31:0] rs2, logic [3:0] be,
                    logic [31:0] wd);
    ack_delay = 1;
    exp_mem.push_back('{1'b1, {a[31:2], 2'b00}, be, wd});
    exp_resp.push_back('{1'b0, 1'b0, 5'd0, 32'd0});
    issue(1, f3, a, rs2, 5'd7);
    drain();
  endtask

  task automatic flt(bit s, logic [2:0] f3, logic [31:0] a);
    int c;
    exp_resp.push_back('{1'b1, 1'b0, 5'd0, 32'd0});
    set_req(s, f3, a, 32'h1111_2222, 5'd9);
    wait_accept(c);
    req_valid = 0;
    @(negedge clk);
    chk("fault_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("fault_ready_next", {31'd0, req_ready}, 32'd1);
    drain();
  endtask

  initial begin
    int c0, c1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    @(posedge clk);
    #1;

    ld(3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 5'd5,
       32'hDEAD_BEEF, 2);
    ld(3'b000, 32'h0000_2003, 32'h80FF_FFFF, 5'd6,
       32'hFFFF_FF80, 0);
    ld(3'b100, 32'h0000_2003, 32'h80FF_FFFF, 5'd6,
       32'h0000_0080, 1);
    ld(3'b001, 32'h0000_2002, 32'h8001_1234, 5'd10,
       32'hFFFF_8001, 0);
    ld(3'b101, 32'h0000_2002, 32'h8001_1234, 5'd11,
       32'h0000_8001, 0);
    ld(3'b001, 32'h0000_2000, 32'h8001_9234, 5'd12,
       32'hFFFF_9234, 0);

    st(3'b001, 32'h0000_0102, 32'h1234_BEEF, 4'b1100,
       32'hBEEF_BEEF);
    st(3'b000, 32'h0000_0003, 32'h0000_00A5, 4'b1000,
       32'hA5A5_A5A5);
    st(3'b010, 32'h0000_0008, 32'hCAFE_F00D, 4'b1111,
       32'hCAFE_F00D);

    flt(0, 3'b010, 32'h0000_0101);
    flt(0, 3'b011, 32'h0000_0000);
    flt(0, 3'b001, 32'h0000_0001);
    flt(1, 3'b100, 32'h0000_0000);

    // reset in 2nd BUSY cycle, late ack must be ignored
    manual = 1;
    mem_ack = 0;
    issue(0, 3'b010, 32'h0000_0040, 32'd0, 5'd3);
    chk("busy1_req", {31'd0, mem_req}, 32'd1);
    @(posedge clk);
    #1;
    chk("busy2_req", {31'd0, mem_req}, 32'd1);
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    mem_ack = 1;
    mem_rdata = 32'h5555_AAAA;
    chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    mem_ack = 0;
    chk("ack_ignored_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    manual = 0;

    // back-to-back SW with req_valid held high
    ack_delay = 0;
    exp_mem.push_back('{1'b1, 32'h10, 4'b1111, 32'h1122_3344});
    exp_resp.push_back('{1'b0, 1'b0, 5'd0, 32'd0});
    exp_mem.push_back('{1'b1, 32'h14, 4'b1111, 32'h5566_7788});
    exp_resp.push_back('{1'b0, 1'b0, 5'd0, 32'd0});
    set_req(1, 3'b010, 32'h10, 32'h1122_3344, 5'd1);
    wait_accept(c0);
    set_req(1, 3'b010, 32'h14, 32'h5566_7788, 5'd2);
    @(negedge clk);
    chk("b2b_stall1", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("b2b_stall2", {31'd0, stall}, 32'd1);
    wait_accept(c1);
    req_valid = 0;
    chk("b2b_spacing", c1 - c0, 32'd3);
    drain();

    chk("exp_mem_empty", exp_mem.size(), 32'd0);
    chk("exp_resp_empty", exp_resp.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
